rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
// - Shares the register file's single write port (we/writeA3/data) between two write-back
//   producers: ALU and load/store unit (LSU).
// - Keeps a pending-write scoreboard so decode can stall on RAW hazards.
// - Sits between the execute/memory stages and reg_file; drives reg_file write inputs directly.
// PARAMETERS
// - XLEN      32  data width of write-back values
// - REG_AW    5   register address width (2**REG_AW registers; x0 hardwired zero)
// PORTS
// - clk          in   1       rising-edge clock; single clock domain
// - rst_n        in   1       asynchronous, active-low reset
// - alu_valid    in   1       ALU has a write-back pending
// - alu_ready    out  1       ALU write-back accepted this cycle
// - alu_rd       in   REG_AW  ALU destination register
// - alu_data     in   XLEN    ALU result
// - lsu_valid    in   1       LSU has a write-back pending
// - lsu_ready    out  1       LSU write-back accepted this cycle
// - lsu_rd       in   REG_AW  LSU destination register
// - lsu_data     in   XLEN    load data
// - alloc_valid  in   1       decode issued an instruction that will write alloc_rd
// - alloc_rd     in   REG_AW  destination being allocated
// - rs1, rs2     in   REG_AW  decode source registers
// - rs1_busy     out  1       rs1 has a write outstanding (combinational from busy_vec)
// - rs2_busy     out  1       rs2 has a write outstanding
// - rf_we        out  1       to reg_file we
// - rf_waddr     out  REG_AW  to reg_file writeA3
// - rf_wdata     out  XLEN    to reg_file data
// - busy_vec     out  2**REG_AW  scoreboard state; bit 0 always 0
// BEHAVIOUR
// - Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, last_grant=LSU
//   (ALU wins first contention); ready outputs 0 while in reset.
// - Handshake: transfer when valid && ready on a clk edge. Producer holds rd/data stable
//   while valid && !ready. ready may depend on valid; valid must not depend on ready.
// - Arbitration (combinational grant, at most one ready per cycle):
//   - only one valid: grant it
//   - both valid: grant the requester not in last_grant (round-robin)
//   - last_grant updates only on a completed transfer
// - Write port registered: transfer at edge N -> rf_we=1, rf_waddr, rf_wdata during cycle N+1;
//   reg_file commits at edge N+1. No back-pressure from reg_file -> one transfer per cycle
//   sustained; rf_we deasserts the cycle after no transfer.
// - x0: transfer with rd=0 completes the handshake but rf_we stays 0 (waddr/wdata don't-care);
//   alloc_rd=0 ignored; rs1_busy/rs2_busy=0 for x0.
// - Scoreboard: alloc_valid sets busy_vec[alloc_rd] at the edge. The edge where rf_we=1 clears
//   busy_vec[rf_waddr]. Same register set and cleared on one edge -> set wins (newer producer).
// - rsN_busy remains 1 through the cycle rf_we is high (no bypass); 0 the cycle after.
// - Reset mid-operation: in-flight writes and busy bits discarded; producers re-issue.
// STRUCTURE
// - Shared package rf_pkg: XLEN, REG_AW, REG_X0 constant, requester-id enum {REQ_ALU, REQ_LSU}.
// - One sub-module: rr_arb2 (2-way round-robin arbiter: req[1:0], xfer -> gnt[1:0], last_grant).
// - Scoreboard, x0 filter and write-port register stay in this module.
// TESTING
// - Reset: rst_n=0 mid-cycle with alu_valid=1 -> rf_we=0, busy_vec=0 immediately (async).
// - Single ALU write: alloc rd=1, then alu_valid, rd=1, data=32'hEEADB00C -> alu_ready same
//   cycle; next cycle rf_we=1, waddr=1, wdata=EEADB00C; busy_vec[1] 1 -> 0 after that edge.
// - Contention: both valid 3 cycles (ALU rd=2/56AB9900, LSU rd=3/12345678, hold until accepted)
//   -> grants ALU, LSU, ALU; exactly one ready per cycle.
// - x0 write: LSU rd=0, data=FFFFFFFF -> lsu_ready=1, rf_we stays 0; alloc_rd=0 leaves busy_vec=0.
// - Set/clear collision: rf_we=1, waddr=5 while alloc_valid=1, alloc_rd=5 -> busy_vec[5]=1.
// - Hazard: alloc rd=7, rs1=7 -> rs1_busy=1 until the edge after rf_we with waddr=7, then 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and requester ids for the register-file write-back path.
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 2 ** REG_AW;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    // Requester ids; the value doubles as the grant/request bit index.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a combinational grant and a registered
// last-grant pointer.
//
// Handshake: a request is a producer's valid.
// A grant is that producer's ready.
// A transfer is valid && ready on a rising clk edge.
// gnt depends on req, but req never depends on gnt.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_xfer,
    output logic [1:0] o_gnt,
    output req_id_e    o_last_grant
);

    req_id_e r_last_grant;

    // Grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (r_last_grant == REQ_LSU) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    // Pointer moves only when a granted request actually transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_LSU;
        end else if (i_xfer) begin
            r_last_grant <= o_gnt[0] ? REQ_ALU : REQ_LSU;
        end
    end

    assign o_last_grant = r_last_grant;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between the ALU and the LSU.
// It also keeps a pending-write scoreboard, which decode uses to detect RAW hazards.
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              alloc_valid,
    input  logic [REG_AW-1:0] alloc_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [NREG-1:0]   busy_vec
);

    logic [1:0]        w_gnt;
    logic              w_alu_xfer;
    logic              w_lsu_xfer;
    logic              w_xfer;
    logic [REG_AW-1:0] w_xfer_rd;
    logic [XLEN-1:0]   w_xfer_data;
    logic [NREG-1:0]   w_busy_nxt;
    req_id_e           w_last_grant;

    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic [NREG-1:0]   r_busy;

    rr_arb2 u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        ({lsu_valid, alu_valid}),
        .i_xfer       (w_xfer),
        .o_gnt        (w_gnt),
        .o_last_grant (w_last_grant)
    );

    // While reset is asserted, no ready is offered, so nothing can transfer.
    assign alu_ready  = w_gnt[0] & rst_n;
    assign lsu_ready  = w_gnt[1] & rst_n;
    assign w_alu_xfer = alu_valid & alu_ready;
    assign w_lsu_xfer = lsu_valid & lsu_ready;
    assign w_xfer     = w_alu_xfer | w_lsu_xfer;

    // Select the payload of whichever producer transfers this cycle.
    always_comb begin
        w_xfer_rd   = alu_rd;
        w_xfer_data = alu_data;
        if (w_lsu_xfer) begin
            w_xfer_rd   = lsu_rd;
            w_xfer_data = lsu_data;
        end
    end

    // Write port register. An x0 transfer still handshakes but never raises rf_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_xfer && (w_xfer_rd != REG_X0);
            if (w_xfer) begin
                r_rf_waddr <= w_xfer_rd;
                r_rf_wdata <= w_xfer_data;
            end
        end
    end

    // Scoreboard next state. The clear is applied first and the set second,
    // so a newer allocation of the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_we) begin
            w_busy_nxt[r_rf_waddr] = 1'b0;
        end
        if (alloc_valid && (alloc_rd != REG_X0)) begin
            w_busy_nxt[alloc_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign busy_vec = r_busy;
    assign rs1_busy = (rs1 != REG_X0) && r_busy[rs1];
    assign rs2_busy = (rs2 != REG_X0) && r_busy[rs2];

endmodule
